p2s_symbol_serializer: RTL and testbench

//  Transmit-side parallel-to-serial converter for the QAM link; the mirror of the receive-side S2P.

---
 rtl/qam_pkg.sv | 18 +
 rtl/sym_fifo.sv | 51 +++++
 rtl/p2s_symbol_serializer.sv | 142 ++++++++++++++
 tb/tb_p2s_symbol_serializer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qam_pkg.sv
// Shared QAM link definitions: default symbol width, idle symbol,
// serializer state encoding and an index-width helper.
package qam_pkg;

    localparam int SYM_BITS_DEF = 2;
    localparam int IDLE_SYM_DEF = 0;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Width of a counter/index covering 0..n-1, never below 1 bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sym_fifo.sv
// Synchronous symbol FIFO, DEPTH x WIDTH, first-word fall-through.
// Ports: clock, reset (sync, active-low flush), push, pop, din, dout,
// full, empty. Push on full and pop on empty are ignored.
module sym_fifo
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Extra pointer bit separates full from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (reset && push && !full) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/p2s_symbol_serializer.sv
// QAM transmit P2S: buffers symbols and shifts them out LSB first,
// each bit held BIT_PERIOD clocks, with strobe/index/start framing.
// Ports: clock, reset (sync, active-low), sym_in/sym_valid/sym_ready,
// ser_out, bit_strobe, bit_idx, sym_start, busy, underrun.
// Option macro P2S_IDLE_FILL_EN: send IDLE_SYM on underrun and stay
// in SHIFT; otherwise an empty FIFO at a symbol boundary returns to IDLE.
module p2s_symbol_serializer
    import qam_pkg::*;
#(
    parameter int                  SYM_BITS   = SYM_BITS_DEF,
    parameter int                  BIT_PERIOD = 4,
    parameter int                  FIFO_DEPTH = 2,
    parameter logic [SYM_BITS-1:0] IDLE_SYM   = SYM_BITS'(IDLE_SYM_DEF)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [SYM_BITS-1:0]        sym_in,
    input  logic                       sym_valid,
    output logic                       sym_ready,
    output logic                       ser_out,
    output logic                       bit_strobe,
    output logic [idx_w(SYM_BITS)-1:0] bit_idx,
    output logic                       sym_start,
    output logic                       busy,
    output logic                       underrun
);

    localparam int IW = idx_w(SYM_BITS);
    localparam int BW = idx_w(BIT_PERIOD);
    localparam logic [BW-1:0] BAUD_MAX = BW'(BIT_PERIOD - 1);
    localparam logic [IW-1:0] IDX_MAX  = IW'(SYM_BITS - 1);

    state_t              state, state_n;
    logic [BW-1:0]       baud_cnt, baud_n;
    logic [IW-1:0]       idx_n, idx_inc;
    logic [SYM_BITS-1:0] shreg, shreg_n, load_sym;
    logic [SYM_BITS-1:0] fifo_dout;
    logic                ser_n, strobe_n, start_n, under_n;
    logic                load, pop, push;
    logic                fifo_full, fifo_empty;

    assign sym_ready = reset & ~fifo_full;
    assign push      = sym_valid & sym_ready;
    assign busy      = (state == SHIFT);
    assign idx_inc   = bit_idx + 1'b1;

    sym_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SYM_BITS)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (sym_in),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_n  = state;
        baud_n   = baud_cnt;
        idx_n    = bit_idx;
        shreg_n  = shreg;
        ser_n    = ser_out;
        strobe_n = 1'b0;
        start_n  = 1'b0;
        under_n  = 1'b0;
        load     = 1'b0;
        load_sym = fifo_dout;
        pop      = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    load = 1'b1;
                    pop  = 1'b1;
                end
            end
            SHIFT: begin
                if (baud_cnt != BAUD_MAX) begin
                    baud_n = baud_cnt + 1'b1;
                end else if (bit_idx != IDX_MAX) begin
                    baud_n   = '0;
                    idx_n    = idx_inc;
                    ser_n    = shreg[idx_inc];
                    strobe_n = 1'b1;
                end else if (!fifo_empty) begin
                    load = 1'b1;
                    pop  = 1'b1;
                end else begin
`ifdef P2S_IDLE_FILL_EN
                    load     = 1'b1;
                    load_sym = IDLE_SYM;
                    under_n  = 1'b1;
`else
                    // Park the shifter on the idle pattern.
                    state_n = IDLE;
                    baud_n  = '0;
                    idx_n   = '0;
                    ser_n   = 1'b0;
                    shreg_n = IDLE_SYM;
`endif
                end
            end
            default: state_n = IDLE;
        endcase
        // Symbol start: common to IDLE exit, back-to-back and fill.
        if (load) begin
            state_n  = SHIFT;
            shreg_n  = load_sym;
            ser_n    = load_sym[0];
            idx_n    = '0;
            baud_n   = '0;
            strobe_n = 1'b1;
            start_n  = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            ser_out    <= 1'b0;
            bit_strobe <= 1'b0;
            sym_start  <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state      <= state_n;
            baud_cnt   <= baud_n;
            bit_idx    <= idx_n;
            shreg      <= shreg_n;
            ser_out    <= ser_n;
            bit_strobe <= strobe_n;
            sym_start  <= start_n;
            underrun   <= under_n;
        end
    end

endmodule

// File: tb/tb_p2s_symbol_serializer.sv
// Self-checking bench for p2s_symbol_serializer: scoreboard of
// expected serial bits plus directed framing/timing checks.
module tb_p2s_symbol_serializer;

    localparam int BP = 4;

    logic       clock;
    logic       reset;
    logic [1:0] sym_in;
    logic       sym_valid;
    logic       sym_ready;
    logic       ser_out;
    logic       bit_strobe;
    logic [0:0] bit_idx;
    logic       sym_start;
    logic       busy;
    logic       underrun;

    logic [1:0] f_in;
    logic       f_valid;
    logic       f_ready;
    logic       f_ser;
    logic       f_strobe;
    logic [0:0] f_idx;
    logic       f_start;
    logic       f_busy;
    logic       f_under;

    p2s_symbol_serializer #(
        .SYM_BITS   (2),
        .BIT_PERIOD (BP),
        .FIFO_DEPTH (2),
        .IDLE_SYM   (2'b00)
    ) u_dut (
        .clock      (clock),
        .reset      (reset),
        .sym_in     (sym_in),
        .sym_valid  (sym_valid),
        .sym_ready  (sym_ready),
        .ser_out    (ser_out),
        .bit_strobe (bit_strobe),
        .bit_idx    (bit_idx),
        .sym_start  (sym_start),
        .busy       (busy),
        .underrun   (underrun)
    );

    p2s_symbol_serializer #(
        .SYM_BITS   (2),
        .BIT_PERIOD (1),
        .FIFO_DEPTH (2),
        .IDLE_SYM   (2'b00)
    ) u_fast (
        .clock      (clock),
        .reset      (reset),
        .sym_in     (f_in),
        .sym_valid  (f_valid),
        .sym_ready  (f_ready),
        .ser_out    (f_ser),
        .bit_strobe (f_strobe),
        .bit_idx    (f_idx),
        .sym_start  (f_start),
        .busy       (f_busy),
        .underrun   (f_under)
    );

    typedef struct {
        logic b;
        int   idx;
        logic st;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   n_strobe = 0;
    int   last_strobe = 0;
    int   last_start = 0;
    bit   have_start = 0;
    bit   gapless_chk = 0;
`ifdef P2S_IDLE_FILL_EN
    localparam bit FILL = 1'b1;
`else
    localparam bit FILL = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    // Record expected bits for every accepted push.
    always @(posedge clock) begin
        if (!reset) begin
            sbq.delete();
        end else if (sym_valid && sym_ready) begin
            for (int i = 0; i < 2; i++) begin
                sbq.push_back('{b: sym_in[i], idx: i, st: (i == 0)});
            end
        end
    end

    // Check every strobed bit against the scoreboard.
    always @(negedge clock) begin
        exp_t e;
        if (reset && bit_strobe) begin
            n_strobe++;
            if (!sym_start) begin
                chk("bit_gap", cyc - last_strobe, BP);
            end
            if (sym_start && gapless_chk && have_start) begin
                chk("sym_gap", cyc - last_start, 2 * BP);
            end
            if (sym_start) begin
                last_start = cyc;
                have_start = 1'b1;
            end
            last_strobe = cyc;
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("sb_ser", ser_out, e.b);
                chk("sb_idx", bit_idx, e.idx);
                chk("sb_start", sym_start, e.st);
            end else if (FILL) begin
                chk("fill_ser", ser_out, 0);
            end else begin
                chk("sb_extra", bit_strobe, 0);
            end
        end
    end

    task automatic rst_pulse();
        @(posedge clock);
        #1 reset = 1'b0;
        sym_valid = 1'b0;
        f_valid = 1'b0;
        @(posedge clock);
        #1 reset = 1'b1;
    endtask

    task automatic push_one(input logic [1:0] v);
        sym_in = v;
        sym_valid = 1'b1;
        @(posedge clock);
        #1 sym_valid = 1'b0;
    endtask

    initial begin
        logic [1:0] t3v [3];
        bit ok;
        reset = 1'b0;
        sym_in = 2'b11;
        sym_valid = 1'b1;
        f_in = 2'b00;
        f_valid = 1'b0;

        // T1: reset held with sym_valid high.
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("t1_outs",
                {ser_out, bit_strobe, sym_start, busy, underrun,
                 bit_idx, sym_ready}, 0);
        end
        @(posedge clock);
        #1 reset = 1'b1;
        sym_valid = 1'b0;
        repeat (4) @(negedge clock);
        chk("t1_busy", busy, 0);
        chk("t1_nostrobe", n_strobe, 0);
        chk("t1_ready", sym_ready, 1);

        // T2: single symbol 10, BIT_PERIOD=4 timing.
        @(posedge clock);
        #1 push_one(2'b10);
        @(negedge clock);
        chk("t2_pre_busy", busy, 0);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clock);
            chk($sformatf("t2_ser_%0d", k), ser_out, (k >= 5 && k <= 8));
            chk($sformatf("t2_stb_%0d", k), bit_strobe,
                (k == 1 || k == 5 || (FILL && k == 9)));
            chk($sformatf("t2_st_%0d", k), sym_start,
                (k == 1 || (FILL && k == 9)));
            chk($sformatf("t2_busy_%0d", k), busy, (k <= 8 || FILL));
        end
        rst_pulse();

        // T3: three symbols with sym_valid held, gapless output.
        t3v[0] = 2'b01;
        t3v[1] = 2'b11;
        t3v[2] = 2'b00;
        n_strobe = 0;
        have_start = 1'b0;
        gapless_chk = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sym_in = t3v[i];
            sym_valid = 1'b1;
            ok = 1'b0;
            for (int w = 0; w < 40 && !ok; w++) begin
                @(negedge clock);
                if (sym_ready) begin
                    @(posedge clock);
                    #1 ok = 1'b1;
                end
            end
            if (!ok) chk("t3_push_to", sym_ready, 1);
        end
        @(negedge clock);
        chk("t3_full", sym_ready, 0);
        sym_valid = 1'b0;
        for (int w = 0; w < 100 && sbq.size() != 0; w++) begin
            @(negedge clock);
        end
        chk("t3_drain", sbq.size(), 0);
        chk("t3_strobes", n_strobe, 6);
        gapless_chk = 1'b0;
        rst_pulse();

        // T4: reset during bit 1 with one symbol queued.
        sym_in = 2'b11;
        sym_valid = 1'b1;
        @(posedge clock);
        #1 sym_in = 2'b00;
        @(posedge clock);
        #1 sym_valid = 1'b0;
        for (int w = 0; w < 20; w++) begin
            @(negedge clock);
            if (busy && bit_idx == 1'b1) break;
        end
        chk("t4_bit1", bit_idx, 1);
        @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk("t4_outs",
            {ser_out, bit_strobe, sym_start, busy, underrun,
             bit_idx, sym_ready}, 0);
        @(posedge clock);
        #1 reset = 1'b1;
        n_strobe = 0;
        repeat (12) @(negedge clock);
        chk("t4_nostrobe", n_strobe, 0);
        chk("t4_busy", busy, 0);

        // T5: BIT_PERIOD=1, 10 then 01 back-to-back.
        @(posedge clock);
        #1 f_in = 2'b10;
        f_valid = 1'b1;
        @(posedge clock);
        #1 f_in = 2'b01;
        @(posedge clock);
        #1 f_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clock);
            if (k <= 4) begin
                chk($sformatf("t5_ser_%0d", k), f_ser, (k == 2 || k == 3));
                chk($sformatf("t5_stb_%0d", k), f_strobe, 1);
                chk($sformatf("t5_st_%0d", k), f_start, (k == 1 || k == 3));
                chk($sformatf("t5_idx_%0d", k), f_idx, (k == 2 || k == 4));
            end else begin
                chk("t5_busy_end", f_busy, FILL);
                chk("t5_under", f_under, FILL);
            end
        end
        rst_pulse();

        // T6: single symbol 11, behaviour at the empty boundary.
        @(posedge clock);
        #1 push_one(2'b11);
        @(negedge clock);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            if (k == 9) begin
                chk("t6_busy", busy, FILL);
                chk("t6_under", underrun, FILL);
                chk("t6_ser", ser_out, 0);
            end
            if (k == 10) chk("t6_under_pulse", underrun, 0);
        end
        rst_pulse();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
